// File: rtl/obuf_1x1_reader_pkg.sv
// Shared definitions for the output-buffer reader: FSM encoding and a width helper.
package obuf_1x1_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  // Address width that stays at least one bit for a single-pixel map.
  function automatic int addr_w(input int npix);
    return (npix > 1) ? $clog2(npix) : 1;
  endfunction

endpackage

// File: rtl/obuf_1x1_reader_skid_fifo2.sv
// Two-entry FIFO with same-cycle push/pop; head register drives dout directly.
module skid_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             do_pop, do_push;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = din;
        else                 tail_d = din;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; with one entry the new word becomes the head.
        if (count_q == 2'd1) begin
          head_d = din;
        end else begin
          head_d = tail_q;
          tail_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= 2'd0;
    else     count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign dout  = head_q;
  assign count = count_q;

endmodule

// File: rtl/obuf_1x1_reader.sv
// Streams every pixel word of the output buffer, in index order, onto a valid/ready port.
module obuf_1x1_reader
  import obuf_1x1_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OUT_CHANNELS = 3,
  parameter int IN_WIDTH     = 5,
  parameter int IN_HEIGHT    = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic [addr_w(IN_WIDTH*IN_HEIGHT)-1:0] rd_addr,
  output logic                                  rd_en,
  input  logic [DATA_WIDTH*OUT_CHANNELS-1:0]    rd_data,
  output logic [DATA_WIDTH*OUT_CHANNELS-1:0]    o_data,
  output logic                                  o_valid,
  input  logic                                  o_ready,
  output logic                                  o_last
);

  localparam int NPIX = IN_WIDTH * IN_HEIGHT;
  localparam int AW   = addr_w(NPIX);
  localparam int PW   = DATA_WIDTH * OUT_CHANNELS;
  localparam logic [AW-1:0] LAST_IDX = AW'(NPIX - 1);

  rd_state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] out_idx_q, out_idx_d;
  logic          done_q, done_d;
  logic [1:0]    fifo_count;
  logic [PW-1:0] fifo_dout;
  logic          pop;

  // A read's data lands at the edge closing its rd_en cycle, so nothing is
  // outstanding when the next request is decided: occupancy alone gates reads.
  assign rd_en   = (state_q == RUN) && (fifo_count < 2'd2);
  assign rd_addr = rd_en ? addr_q : '0;
  assign o_valid = (fifo_count != 2'd0);
  assign pop     = o_valid && o_ready;
  assign o_data  = o_valid ? fifo_dout : '0;
  assign o_last  = o_valid && (out_idx_q == LAST_IDX);
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

  skid_fifo2 #(
    .WIDTH(PW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (rd_en),
    .din  (rd_data),
    .pop  (pop),
    .dout (fifo_dout),
    .count(fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    out_idx_d = out_idx_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          addr_d    = '0;
          out_idx_d = '0;
        end
      end
      RUN: begin
        if (rd_en) begin
          if (addr_q == LAST_IDX) begin
            state_d = DRAIN;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end
      DRAIN: ;
      default: state_d = IDLE;
    endcase

    if (pop) begin
      out_idx_d = (out_idx_q == LAST_IDX) ? '0 : out_idx_q + AW'(1);
    end
    if ((state_q == DRAIN) && pop && (out_idx_q == LAST_IDX)) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      out_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      out_idx_q <= out_idx_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_obuf_1x1_reader.sv
// Randomised bench for obuf_1x1_reader against a transaction-count reference model.
module tb_obuf_1x1_reader;

  localparam int DW   = 8;
  localparam int OC   = 3;
  localparam int W    = 5;
  localparam int H    = 5;
  localparam int NPIX = W * H;
  localparam int AW   = $clog2(NPIX);
  localparam int PW   = DW * OC;

  logic clk = 1'b0;
  logic rst, start, o_ready;
  logic busy, done, rd_en, o_valid, o_last;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data, o_data, garbage;

  logic start1, o_ready1;
  logic busy1, done1, rd_en1, o_valid1, o_last1;
  logic [0:0]    rd_addr1;
  logic [PW-1:0] rd_data1, o_data1;

  int checks = 0;
  int passed = 0;

  // Reference model: frame activity plus counts of reads, pops and FIFO occupancy.
  bit   active, done_exp, prev_stall;
  int   occ, nrd, nout;
  logic [PW-1:0] prev_data;
  int   words, dones, reads_seen;
  int   cyc;

  always #5 clk = ~clk;

  obuf_1x1_reader #(
    .DATA_WIDTH(DW), .OUT_CHANNELS(OC), .IN_WIDTH(W), .IN_HEIGHT(H)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last)
  );

  obuf_1x1_reader #(
    .DATA_WIDTH(DW), .OUT_CHANNELS(OC), .IN_WIDTH(1), .IN_HEIGHT(1)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .rd_addr(rd_addr1), .rd_en(rd_en1), .rd_data(rd_data1),
    .o_data(o_data1), .o_valid(o_valid1), .o_ready(o_ready1), .o_last(o_last1)
  );

  function automatic logic [PW-1:0] pix(input int p);
    return {8'(p + 2), 8'(p + 1), 8'(p)};
  endfunction

  // Buffer answers only while a read is requested; otherwise it shows noise.
  always_comb rd_data  = rd_en  ? pix(int'(rd_addr))  : garbage;
  always_comb rd_data1 = rd_en1 ? pix(int'(rd_addr1)) : garbage;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_last", o_last, 0);
    chk("rst_o_data", o_data, 0);
  endtask

  task automatic model_reset();
    active = 0; done_exp = 0; prev_stall = 0;
    occ = 0; nrd = 0; nout = 0;
  endtask

  // Compare this cycle's outputs with the model, then advance it across the next edge.
  task automatic monitor();
    bit rd_exp, vld_exp, hs;
    rd_exp  = active && (nrd < NPIX) && (occ < 2);
    vld_exp = (occ > 0);
    chk("busy", busy, active);
    chk("done", done, done_exp);
    chk("rd_en", rd_en, rd_exp);
    chk("o_valid", o_valid, vld_exp);
    if (rd_en) chk("rd_addr", rd_addr, nrd);
    else       chk("rd_addr_idle", rd_addr, 0);
    if (o_valid) begin
      chk("o_data", o_data, pix(nout));
      chk("o_last", o_last, nout == NPIX - 1);
      if (prev_stall) chk("stall_hold", o_data, prev_data);
    end else begin
      chk("o_last_idle", o_last, 0);
    end
    if (done) dones++;
    if (rd_en) reads_seen++;

    hs         = vld_exp && o_ready;
    prev_stall = o_valid && !o_ready;
    prev_data  = o_data;
    if (rst) begin
      model_reset();
    end else begin
      done_exp = hs && (nout == NPIX - 1);
      if (rd_exp) nrd++;
      occ = occ + int'(rd_exp) - int'(hs);
      if (hs) begin nout++; words++; end
      if (done_exp) active = 0;
      else if (!active && start) begin active = 1; nrd = 0; nout = 0; end
    end
  endtask

  // mode: 0 ready=1, 1 ready 1,0,0,1, 2 ten-cycle stall, 3 second start, 4 reset mid-frame, 5 random
  task automatic run_frame(input int mode, output int cycles);
    bit seen_done, pulsed, did_rst, stop;
    int rst_c;
    seen_done = 0; pulsed = 0; did_rst = 0; stop = 0; rst_c = 0; cycles = -1;
    words = 0; dones = 0; reads_seen = 0;
    for (int c = 0; c < 400 && !stop; c++) begin
      @(negedge clk);
      garbage = PW'($urandom);
      rst     = 1'b0;
      start   = (c == 0);
      case (mode)
        1:       o_ready = ((c % 4) == 0) || ((c % 4) == 3);
        2:       o_ready = (c > 10);
        5:       o_ready = 1'($urandom_range(0, 1));
        default: o_ready = 1'b1;
      endcase
      if (mode == 3 && active && nout == 10 && !pulsed) begin start = 1'b1; pulsed = 1; end
      if (mode == 4 && active && nout == 12 && !did_rst) begin rst = 1'b1; did_rst = 1; rst_c = c; end
      #1;
      if (mode == 4 && did_rst && c == rst_c + 1) chk_reset_outputs();
      monitor();
      if (mode == 2 && c == 10) begin
        chk("stall_reads", reads_seen, 2);
        chk("stall_valid", o_valid, 1);
        chk("stall_head", o_data, pix(0));
      end
      if (done && !seen_done) begin seen_done = 1; cycles = c; end
      if (mode != 4 && seen_done) stop = 1;
      if (mode == 4 && did_rst && c == rst_c + 6) stop = 1;
    end
    if (mode == 4) begin
      chk("rst_no_done", dones, 0);
    end else begin
      chk("done_seen", seen_done, 1);
      chk("frame_words", words, NPIX);
      chk("frame_dones", dones, 1);
    end
  endtask

  task automatic single_pixel_frame();
    @(negedge clk); start1 = 1'b1; o_ready1 = 1'b1; #1;
    chk("s_busy_idle", busy1, 0);
    @(negedge clk); start1 = 1'b0; #1;
    chk("s_rd_en", rd_en1, 1);
    chk("s_rd_addr", rd_addr1, 0);
    chk("s_busy", busy1, 1);
    chk("s_valid_early", o_valid1, 0);
    @(negedge clk); #1;
    chk("s_valid", o_valid1, 1);
    chk("s_last", o_last1, 1);
    chk("s_data", o_data1, pix(0));
    chk("s_rd_en_off", rd_en1, 0);
    @(negedge clk); #1;
    chk("s_done", done1, 1);
    chk("s_busy_off", busy1, 0);
    chk("s_valid_off", o_valid1, 0);
    @(negedge clk); #1;
    chk("s_done_pulse", done1, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; o_ready = 1'b0;
    start1 = 1'b0; o_ready1 = 1'b1; garbage = '0;
    model_reset();
    words = 0; dones = 0; reads_seen = 0;
    repeat (2) @(negedge clk);
    #1 chk_reset_outputs();
    @(negedge clk); rst = 1'b0;

    run_frame(0, cyc);
    chk("start_to_done", cyc, 27);
    run_frame(1, cyc);
    run_frame(2, cyc);
    run_frame(3, cyc);
    run_frame(4, cyc);
    run_frame(0, cyc);
    chk("restart_start_to_done", cyc, 27);
    run_frame(5, cyc);
    single_pixel_frame();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
